fft_input_collector: RTL
========================

// Module: fft_input_collector
// PURPOSE
//  Serial-to-parallel front end for the radix-4 butterfly stage.
//  - Accepts one complex sample per handshake; packs N_POINT samples into one flat frame in natural order.
//  - Ping-pong buffered: one bank fills while the other is held for the butterfly.
//  - Short frames (early s_last_i) are zero-padded and flagged.
// PARAMETERS
//  DATA_WIDTH  8  signed width of each real/imag sample
//  N_POINT     4  samples per frame; multiple of 4, >= 4
// PORTS
//  sys_clk_i    in   1                    clock, all logic on rising edge
//  rst_n_i      in   1                    synchronous active-low reset
//  s_valid_i    in   1                    input sample valid
//  s_ready_o    out  1                    collector can accept a sample
//  s_real_i     in   DATA_WIDTH           sample real part, signed
//  s_imag_i     in   DATA_WIDTH           sample imag part, signed
//  s_last_i     in   1                    sample closes the current frame
//  m_valid_o    out  1                    frame available
//  m_ready_i    in   1                    downstream consumes the frame
//  xn_real_o    out  DATA_WIDTH*N_POINT   sample k at [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
//  xn_imag_o    out  DATA_WIDTH*N_POINT   same packing as xn_real_o
//  m_short_o    out  1                    frame closed early by s_last_i; padded with zeros
// BEHAVIOUR
//  - Clock/reset: one clock sys_clk_i; reset rst_n_i is synchronous, active-low.
//  - Reset state:
//    - s_ready_o = 1; m_valid_o = 0; m_short_o = 0; xn_real_o = xn_imag_o = 0.
//    - Both banks cleared to zero and EMPTY; write counter = 0; write and read bank pointers = bank 0.
//  - Handshakes:
//    - Input accept = s_valid_i & s_ready_o. Output transfer = m_valid_o & m_ready_i.
//  - Bank FSM, one per bank, states EMPTY -> FILLING -> FULL -> EMPTY:
//    - EMPTY -> FILLING: write pointer selects the bank.
//    - FILLING -> FULL: on the accept with count == N_POINT-1, or on an accept with s_last_i = 1.
//    - FULL -> EMPTY: on an output transfer; the bank is cleared to zero in the same edge.
//  - Write path:
//    - Accepted sample is stored in slot count of the write bank; count increments.
//    - On frame close: count resets to 0 and the write pointer toggles.
//    - s_last_i at count == N_POINT-1 is a normal full frame (m_short_o = 0).
//  - s_ready_o = 1 iff the write bank is not FULL (registered from bank state).
//    - Drops the cycle after the second bank closes while the first is still FULL.
//  - Output path:
//    - m_valid_o = read bank is FULL. xn_*_o and m_short_o are driven from the read bank.
//    - Output data is stable while m_valid_o & !m_ready_i.
//    - On a transfer, the read pointer toggles.
//  - Latency: closing sample accepted at edge t -> m_valid_o = 1 after edge t (1 cycle).
//  - Simultaneous events:
//    - A transfer on bank A in the same cycle bank B closes: no bubble.
//    - s_ready_o stays 1; m_valid_o stays 1 and presents bank B next cycle.
//    - A transfer and an accept in the same cycle are both honoured.
//  - Widths: no arithmetic on data; samples are stored bit-exact; padding slots are 0.
//  - Reset mid-frame: the partial frame and any FULL banks are discarded; the next accept lands in slot 0.
// TESTING (N_POINT=4, DATA_WIDTH=8)
//  1. Reset:
//     - Stimulus: hold rst_n_i=0 for 2 cycles.
//     - Response: s_ready_o=1, m_valid_o=0, xn_real_o=0, m_short_o=0.
//  2. Full frame:
//     - Stimulus: real 1,2,3,4 / imag -1,-2,-3,-4 on consecutive cycles, m_ready_i=1.
//     - Response: m_valid_o high 1 cycle after 4th accept.
//     - Values: xn_real_o=32'h04030201, xn_imag_o=32'hFCFDFEFF, m_short_o=0.
//  3. Backpressure:
//     - Stimulus: m_ready_i=0, offer 9 samples.
//     - Response: s_ready_o=0 after 8th accept; 9th is held; frame 1 is stable.
//     - Then m_ready_i=1 for 1 cycle -> frame 2 is presented next cycle; 9th is accepted.
//  4. Short frame:
//     - Stimulus: real 5,6 with s_last_i on 6.
//     - Response: xn_real_o=32'h00000605, m_short_o=1; next frame starts at slot 0.
//  5. Reset mid-frame:
//     - Stimulus: 2 samples, then rst_n_i=0 for 1 cycle, then 4 samples 9..12.
//     - Response: only one frame is emitted, xn_real_o=32'h0C0B0A09.
//  6. Ping-pong overlap:
//     - Stimulus: frame B closes in the same cycle frame A transfers; stream is continuous.
//     - Response: s_ready_o never drops; frames are emitted back to back.

Source files
------------

// File: rtl/fft_input_collector_if.sv
// Sample-in / frame-out bundle for fft_input_collector.
// slave is the collector's view, master is the producer/consumer side.
interface fft_input_collector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_POINT    = 4
);
    logic                          s_valid_i;
    logic                          s_ready_o;
    logic [DATA_WIDTH-1:0]         s_real_i;
    logic [DATA_WIDTH-1:0]         s_imag_i;
    logic                          s_last_i;
    logic                          m_valid_o;
    logic                          m_ready_i;
    logic [DATA_WIDTH*N_POINT-1:0] xn_real_o;
    logic [DATA_WIDTH*N_POINT-1:0] xn_imag_o;
    logic                          m_short_o;

    modport slave (
        input  s_valid_i, s_real_i, s_imag_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, xn_real_o, xn_imag_o, m_short_o
    );

    modport master (
        output s_valid_i, s_real_i, s_imag_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, xn_real_o, xn_imag_o, m_short_o
    );
endinterface

// File: rtl/fft_input_collector.sv
// Serial-to-parallel ping-pong collector: packs N_POINT complex samples per frame
// for the radix-4 butterfly; short frames are zero-padded and flagged.
module fft_input_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int N_POINT    = 4
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_n_i,
    fft_input_collector_if.slave  bus
);
    localparam int CW = $clog2(N_POINT);
    localparam logic [CW-1:0] LAST_SLOT = CW'(N_POINT - 1);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] FILLING = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

    logic [1:0]            state     [2];
    logic [1:0]            state_nxt [2];
    logic [DATA_WIDTH-1:0] mem_r     [2][N_POINT];
    logic [DATA_WIDTH-1:0] mem_i     [2][N_POINT];
    logic                  bank_short[2];
    logic                  wr_ptr, rd_ptr, wr_nxt;
    logic [CW-1:0]         count;
    logic                  ready_q, ready_nxt;
    logic                  accept, xfer, close, m_valid;

    assign m_valid = (state[rd_ptr] == FULL);
    assign accept  = bus.s_valid_i & ready_q;
    assign xfer    = m_valid & bus.m_ready_i;
    assign close   = accept & ((count == LAST_SLOT) | bus.s_last_i);

    // ready is registered from the post-edge bank state, so a transfer that frees
    // the next write bank in the same edge another bank closes keeps ready high.
    always_comb begin
        state_nxt = state;
        if (xfer)
            state_nxt[rd_ptr] = EMPTY;
        if (state[wr_ptr] == EMPTY)
            state_nxt[wr_ptr] = FILLING;
        if (close)
            state_nxt[wr_ptr] = FULL;
        wr_nxt    = wr_ptr ^ close;
        ready_nxt = (state_nxt[wr_nxt] != FULL);
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned b = 0; b < 2; b++) begin
                state[b]      <= EMPTY;
                bank_short[b] <= 1'b0;
                for (int unsigned k = 0; k < N_POINT; k++) begin
                    mem_r[b][k] <= '0;
                    mem_i[b][k] <= '0;
                end
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_nxt;
            ready_q <= ready_nxt;
            // The read bank is FULL, the write bank never is, so these never collide.
            if (xfer) begin
                rd_ptr             <= ~rd_ptr;
                bank_short[rd_ptr] <= 1'b0;
                for (int unsigned k = 0; k < N_POINT; k++) begin
                    mem_r[rd_ptr][k] <= '0;
                    mem_i[rd_ptr][k] <= '0;
                end
            end
            if (accept) begin
                mem_r[wr_ptr][count] <= bus.s_real_i;
                mem_i[wr_ptr][count] <= bus.s_imag_i;
                count                <= close ? '0 : count + 1'b1;
                if (close)
                    bank_short[wr_ptr] <= (count != LAST_SLOT);
            end
        end
    end

    always_comb begin
        bus.xn_real_o = '0;
        bus.xn_imag_o = '0;
        for (int unsigned k = 0; k < N_POINT; k++) begin
            bus.xn_real_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr][k];
            bus.xn_imag_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_i[rd_ptr][k];
        end
    end

    assign bus.m_valid_o = m_valid;
    assign bus.m_short_o = bank_short[rd_ptr];
    assign bus.s_ready_o = ready_q;
endmodule
